demux_scan_sequencer: RTL

- Upstream control stage for the 1:8 demux.
- Accepts a serial bit stream over a valid/ready handshake and drives the demux's Enable/Select/Data inputs.
- Sweeps channels 0..7 in order, holding each bit on its channel for a programmable dwell time.
- Supports single-scan or continuous operation, with abort and completion signalling.

---
 rtl/demux_scan_sequencer_pkg.sv | 18 +
 rtl/demux_scan_sequencer_if.sv | 45 ++++
 rtl/demux_scan_sequencer_next_ch.sv | 34 +++
 rtl/demux_scan_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/demux_scan_sequencer_pkg.sv
// demux_seq_pkg: shared types and constants for the 1:8 demux scan sequencer.
// The optional channel-mask feature is enabled with DEMUX_SEQ_CH_MASK_EN.
package demux_seq_pkg;

   localparam int NUM_CH      = 8;
   localparam int SEL_W       = 3;
   localparam int DEF_DWELL_W = 8;

   // Index of the highest channel; the end of a full (unmasked) sweep.
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2
   } state_t;

endpackage

// File: rtl/demux_scan_sequencer_if.sv
// demux_scan_sequencer_if: control/handshake bundle between the upstream
// source (master) and the scan sequencer (slave). Channel_Mask_In exists only
// when DEMUX_SEQ_CH_MASK_EN is defined.
interface demux_scan_sequencer_if
   import demux_seq_pkg::*;
#(
   parameter int DWELL_W = DEF_DWELL_W
) ();

   logic               Start_In;
   logic               Abort_In;
   logic               Mode_In;
   logic [DWELL_W-1:0] Dwell_In;
   logic               Data_In;
   logic               Data_Valid_In;
   logic               Data_Ready_Out;
   logic               Enable_Out;
   logic [SEL_W-1:0]   Select_Out;
   logic               Data_Out;
   logic               Busy_Out;
   logic               Ch_Strobe_Out;
   logic               Done_Out;
`ifdef DEMUX_SEQ_CH_MASK_EN
   logic [NUM_CH-1:0]  Channel_Mask_In;
`endif

   modport master (
`ifdef DEMUX_SEQ_CH_MASK_EN
      output Channel_Mask_In,
`endif
      output Start_In, Abort_In, Mode_In, Dwell_In, Data_In, Data_Valid_In,
      input  Data_Ready_Out, Enable_Out, Select_Out, Data_Out,
      input  Busy_Out, Ch_Strobe_Out, Done_Out
   );

   modport slave (
`ifdef DEMUX_SEQ_CH_MASK_EN
      input  Channel_Mask_In,
`endif
      input  Start_In, Abort_In, Mode_In, Dwell_In, Data_In, Data_Valid_In,
      output Data_Ready_Out, Enable_Out, Select_Out, Data_Out,
      output Busy_Out, Ch_Strobe_Out, Done_Out
   );

endinterface

// File: rtl/demux_scan_sequencer_next_ch.sv
// demux_next_ch: combinational next-set-bit finder for the channel mask.
// next_idx is the lowest set bit strictly above ptr, wrap means there is none,
// first_idx is the lowest set bit overall.
module demux_next_ch
   import demux_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  ptr,
   output logic [SEL_W-1:0]  next_idx,
   output logic              wrap,
   output logic [SEL_W-1:0]  first_idx
);

   logic [NUM_CH-1:0] above;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_above
         assign above[gi] = mask[gi] && (SEL_W'(gi) > ptr);
      end
   endgenerate

   assign wrap = ~|above;

   // Priority encode from the top down so the lowest qualifying bit wins.
   always_comb begin
      next_idx  = '0;
      first_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i])  first_idx = SEL_W'(i);
         if (above[i]) next_idx  = SEL_W'(i);
      end
   end

endmodule

// File: rtl/demux_scan_sequencer.sv
// demux_scan_sequencer: takes a serial bit stream over valid/ready and sweeps
// it across the 8 demux channels, holding each bit for a programmable dwell.
// Define DEMUX_SEQ_CH_MASK_EN to visit only the channels selected by a mask.
module demux_scan_sequencer
   import demux_seq_pkg::*;
#(
   parameter int DWELL_W = DEF_DWELL_W,
   parameter int NUM_CH  = 8,
   parameter int SEL_W   = 3
) (
   input  logic                   Clock_In,
   input  logic                   Reset_In,
   demux_scan_sequencer_if.slave  bus
);

   generate
      if (NUM_CH != 8 || SEL_W != 3) begin : g_bad_cfg
         $error("demux_scan_sequencer supports exactly 8 channels");
      end
   endgenerate

   state_t             state_reg, state_next;
   logic [SEL_W-1:0]   ptr_reg, ptr_next;
   logic [SEL_W-1:0]   sel_reg, sel_next;
   logic [DWELL_W-1:0] cnt_reg, cnt_next;
   logic [DWELL_W-1:0] dwell_reg, dwell_next;
   logic               mode_reg, mode_next;
   logic               data_reg, data_next;
   logic               enable_reg, enable_next;
   logic               busy_reg, busy_next;
   logic               strobe_reg, strobe_next;
   logic               done_reg, done_next;
   logic               ready;

   logic [SEL_W-1:0]   nxt_idx;
   logic [SEL_W-1:0]   first_idx;
   logic               last_ch;
   logic               start_ok;

`ifdef DEMUX_SEQ_CH_MASK_EN
   logic [NUM_CH-1:0]  mask_reg;
   logic [NUM_CH-1:0]  mask_sel;

   // While idle the incoming mask picks the first channel; afterwards the latched one rules.
   assign mask_sel = (state_reg == IDLE) ? bus.Channel_Mask_In : mask_reg;
   assign start_ok = |bus.Channel_Mask_In;

   demux_next_ch u_next_ch (
      .mask      (mask_sel),
      .ptr       (ptr_reg),
      .next_idx  (nxt_idx),
      .wrap      (last_ch),
      .first_idx (first_idx)
   );

   // Capture the channel mask together with an accepted start.
   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In)
         mask_reg <= '0;
      else if (state_reg == IDLE && bus.Start_In && start_ok && !bus.Abort_In)
         mask_reg <= bus.Channel_Mask_In;
   end
`else
   assign nxt_idx   = ptr_reg + 1'b1;
   assign first_idx = '0;
   assign last_ch   = (ptr_reg == LAST_CH);
   assign start_ok  = 1'b1;
`endif

   // State and registered-output storage.
   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         sel_reg    <= '0;
         cnt_reg    <= '0;
         dwell_reg  <= '0;
         mode_reg   <= 1'b0;
         data_reg   <= 1'b0;
         enable_reg <= 1'b0;
         busy_reg   <= 1'b0;
         strobe_reg <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         sel_reg    <= sel_next;
         cnt_reg    <= cnt_next;
         dwell_reg  <= dwell_next;
         mode_reg   <= mode_next;
         data_reg   <= data_next;
         enable_reg <= enable_next;
         busy_reg   <= busy_next;
         strobe_reg <= strobe_next;
         done_reg   <= done_next;
      end
   end

   // Next-state and datapath decisions; abort overrides everything else.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      dwell_next = dwell_reg;
      mode_next  = mode_reg;
      data_next  = data_reg;
      case (state_reg)
         IDLE: begin
            if (bus.Start_In && start_ok) begin
               mode_next  = bus.Mode_In;
               dwell_next = (bus.Dwell_In == '0) ? DWELL_W'(1) : bus.Dwell_In;
               ptr_next   = first_idx;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (bus.Data_Valid_In && ready) begin
               data_next  = bus.Data_In;
               sel_next   = ptr_reg;
               cnt_next   = dwell_reg - 1'b1;
               state_next = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_reg == '0) begin
               if (!last_ch) begin
                  ptr_next   = nxt_idx;
                  state_next = WAIT;
               end else if (mode_reg) begin
                  ptr_next   = first_idx;
                  state_next = WAIT;
               end else begin
                  ptr_next   = '0;
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (bus.Abort_In) begin
         state_next = IDLE;
         ptr_next   = '0;
         cnt_next   = '0;
      end
   end

   // Output decode: ready is combinational, the rest are next values of registers.
   always_comb begin
      ready       = (state_reg == WAIT) && !bus.Abort_In;
      enable_next = (state_next == DRIVE);
      busy_next   = (state_next != IDLE);
      strobe_next = (state_next == DRIVE) && (cnt_next == '0);
      done_next   = (state_reg == DRIVE) && (cnt_reg == '0) && last_ch &&
                    !mode_reg && !bus.Abort_In;
   end

   assign bus.Data_Ready_Out = ready;
   assign bus.Enable_Out     = enable_reg;
   assign bus.Select_Out     = sel_reg;
   assign bus.Data_Out       = data_reg;
   assign bus.Busy_Out       = busy_reg;
   assign bus.Ch_Strobe_Out  = strobe_reg;
   assign bus.Done_Out       = done_reg;

endmodule
